// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and helpers for the BCD stopwatch/timer.
// Imported by bcd_digit and stopwatch_timer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Largest legal value of digit idx (digit 0 = least-significant
  // fraction digit); only seconds-tens counts mod 6.
  function automatic logic [3:0] digit_max(
    input int idx,
    input int frac
  );
    return (idx == frac + 1) ? SEC_TENS_MAX : BCD_MAX;
  endfunction

  function automatic logic [3:0] clamp_digit(
    input logic [3:0] d,
    input logic [3:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit step: up/down by one when cin is set.
// Ports: digit (now), down, cin (carry/borrow in), nxt, cout.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic [3:0] digit,
  input  logic       down,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic       cout
);

  logic at_lim;

  assign at_lim = down ? (digit == 4'd0) : (digit == MAX);
  assign cout   = cin & at_lim;

  always_comb begin
    nxt = digit;
    if (cin) begin
      if (down) nxt = at_lim ? MAX : digit - 4'd1;
      else      nxt = at_lim ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// BCD stopwatch / countdown timer core, M..M:SS.F packed BCD.
// In: clk, reset (async high), tick, start_stop, clear, lap,
//   count_down, preset_load, preset_bcd.
// Out: time_bcd, lap_bcd, running, expired, lap_valid.
// Optional lap capture is built when LAP_CAPTURE_EN is defined.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int MIN_DIGITS  = 1,
  parameter int FRAC_DIGITS = 1,
  parameter bit WRAP        = 1'b0,
  localparam int NDIG = MIN_DIGITS + 2 + FRAC_DIGITS,
  localparam int TW   = 4 * NDIG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          start_stop,
  input  logic          clear,
  input  logic          lap,
  input  logic          count_down,
  input  logic          preset_load,
  input  logic [TW-1:0] preset_bcd,
  output logic [TW-1:0] time_bcd,
  output logic [TW-1:0] lap_bcd,
  output logic          running,
  output logic          expired,
  output logic          lap_valid
);

  state_t        state_q, state_d;
  logic [TW-1:0] time_q, time_d;
  logic [TW-1:0] preset_q, preset_d;
  logic [TW-1:0] lap_q, lap_d;
  logic          lapv_q, lapv_d;
  logic          dir_q, dir_d;

  logic [TW-1:0] time_step;
  logic [TW-1:0] preset_cl;
  logic [NDIG:0] cy;
  logic          idle_or_done;
  logic          lap_hit;

  // cy[NDIG] set means the whole value is at its limit:
  // all-max when counting up, all-zero when counting down.
  assign cy[0] = 1'b1;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [3:0] DMAX = digit_max(i, FRAC_DIGITS);

    bcd_digit #(
      .MAX (DMAX)
    ) u_dig (
      .digit (time_q[4*i +: 4]),
      .down  (dir_q),
      .cin   (cy[i]),
      .nxt   (time_step[4*i +: 4]),
      .cout  (cy[i+1])
    );

    assign preset_cl[4*i +: 4] =
      clamp_digit(preset_bcd[4*i +: 4], DMAX);
  end

  assign idle_or_done =
    (state_q == IDLE) || (state_q == DONE);

`ifdef LAP_CAPTURE_EN
  assign lap_hit =
    lap && ((state_q == RUN) || (state_q == PAUSE));
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    preset_d = preset_q;
    dir_d    = dir_q;
    lap_d    = lap_q;
    lapv_d   = lapv_q;

    if (clear) begin
      state_d = IDLE;
      time_d  = count_down ? preset_q : '0;
      lapv_d  = 1'b0;
    end else if (preset_load && idle_or_done) begin
      preset_d = preset_cl;
      time_d   = preset_cl;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE: begin
          dir_d   = count_down;
          state_d = (count_down && time_q == '0)
                    ? DONE : RUN;
        end
        RUN:   state_d = PAUSE;
        PAUSE: state_d = RUN;
        DONE: begin
          time_d  = dir_q ? preset_q : '0;
          state_d = (dir_q && preset_q == '0)
                    ? DONE : RUN;
        end
      endcase
    end else if (lap_hit) begin
      lap_d  = time_q;
      lapv_d = 1'b1;
    end else if (tick && state_q == RUN) begin
      if (cy[NDIG]) begin
        // at 9..9:59.9.. going up, or at zero going down
        if (!dir_q && WRAP) time_d = time_step;
        else                state_d = DONE;
      end else begin
        time_d = time_step;
        if (dir_q && time_step == '0) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      time_q   <= '0;
      preset_q <= '0;
      lap_q    <= '0;
      lapv_q   <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      preset_q <= preset_d;
      lap_q    <= lap_d;
      lapv_q   <= lapv_d;
      dir_q    <= dir_d;
    end
  end

  assign time_bcd  = time_q;
  assign lap_bcd   = lap_q;
  assign lap_valid = lapv_q;
  assign running   = (state_q == RUN);
  assign expired   = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer (default build and
// LAP_CAPTURE_EN), one WRAP=0 and one WRAP=1 instance.
module tb_stopwatch_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic        count_down = 1'b0;
  logic        preset_load = 1'b0;
  logic [15:0] preset_bcd = '0;

  logic [15:0] time_bcd, lap_bcd;
  logic        running, expired, lap_valid;
  logic [15:0] time_w, lap_w;
  logic        running_w, expired_w, lapv_w;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_timer #(
    .MIN_DIGITS  (1),
    .FRAC_DIGITS (1),
    .WRAP        (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start_stop  (start_stop),
    .clear       (clear),
    .lap         (lap),
    .count_down  (count_down),
    .preset_load (preset_load),
    .preset_bcd  (preset_bcd),
    .time_bcd    (time_bcd),
    .lap_bcd     (lap_bcd),
    .running     (running),
    .expired     (expired),
    .lap_valid   (lap_valid)
  );

  stopwatch_timer #(
    .MIN_DIGITS  (1),
    .FRAC_DIGITS (1),
    .WRAP        (1'b1)
  ) dut_w (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start_stop  (start_stop),
    .clear       (clear),
    .lap         (lap),
    .count_down  (count_down),
    .preset_load (preset_load),
    .preset_bcd  (preset_bcd),
    .time_bcd    (time_w),
    .lap_bcd     (lap_w),
    .running     (running_w),
    .expired     (expired_w),
    .lap_valid   (lapv_w)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(
    input logic ss,
    input logic clr,
    input logic lp,
    input logic pl,
    input logic tk
  );
    start_stop  = ss;
    clear       = clr;
    lap         = lp;
    preset_load = pl;
    tick        = tk;
    @(posedge clk);
    #1;
    start_stop  = 1'b0;
    clear       = 1'b0;
    lap         = 1'b0;
    preset_load = 1'b0;
    tick        = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", 32'(time_bcd), 32'h0000);
    chk("rst_run", 32'(running), 32'd0);
    chk("rst_exp", 32'(expired), 32'd0);
    chk("rst_lapv", 32'(lap_valid), 32'd0);
    chk("rst_lap", 32'(lap_bcd), 32'h0000);
    reset = 1'b0;

    // count up 60.0 s
    cyc(1, 0, 0, 0, 0);
    chk("start_run", 32'(running), 32'd1);
    ticks(600);
    chk("up600", 32'(time_bcd), 32'h1000);
    chk("up600_run", 32'(running), 32'd1);

    // pause ignores ticks
    cyc(1, 0, 0, 0, 0);
    chk("pause_run", 32'(running), 32'd0);
    ticks(5);
    chk("pause_hold", 32'(time_bcd), 32'h1000);
    cyc(1, 0, 0, 0, 0);
    chk("resume", 32'(running), 32'd1);

    // clear beats start_stop and tick
    cyc(1, 1, 0, 0, 1);
    chk("prio_time", 32'(time_bcd), 32'h0000);
    chk("prio_run", 32'(running), 32'd0);
    chk("prio_exp", 32'(expired), 32'd0);

    // lap capture at 0:12.3
    cyc(1, 0, 0, 0, 0);
    ticks(123);
    chk("pre_lap", 32'(time_bcd), 32'h0123);
    cyc(0, 0, 1, 0, 0);
`ifdef LAP_CAPTURE_EN
    chk("lap_bcd", 32'(lap_bcd), 32'h0123);
    chk("lap_v", 32'(lap_valid), 32'd1);
    chk("lap_bcd_w", 32'(lap_w), 32'h0123);
`else
    chk("lap_bcd", 32'(lap_bcd), 32'h0000);
    chk("lap_v", 32'(lap_valid), 32'd0);
    chk("lap_bcd_w", 32'(lap_w), 32'h0000);
`endif
    ticks(2);
    chk("lap_keep", 32'(time_bcd), 32'h0125);
    cyc(0, 1, 0, 0, 0);
    chk("clr_lapv", 32'(lap_valid), 32'd0);
    chk("clr_lapv_w", 32'(lapv_w), 32'd0);
    chk("clr_time", 32'(time_bcd), 32'h0000);

    // clamp: C->9, 7 kept, F->5 (sec tens), 0 kept
    preset_bcd = 16'h0F7C;
    cyc(0, 0, 0, 1, 0);
    chk("clamp", 32'(time_bcd), 32'h0579);

    // countdown from 1.0 s
    preset_bcd = 16'h0010;
    cyc(0, 0, 0, 1, 0);
    chk("preset", 32'(time_bcd), 32'h0010);
    count_down = 1'b1;
    cyc(1, 0, 0, 0, 0);
    count_down = 1'b0;
    chk("dn_run", 32'(running), 32'd1);
    ticks(9);
    chk("dn9", 32'(time_bcd), 32'h0001);
    chk("dn9_exp", 32'(expired), 32'd0);
    ticks(1);
    chk("dn10", 32'(time_bcd), 32'h0000);
    chk("dn10_exp", 32'(expired), 32'd1);
    chk("dn10_run", 32'(running), 32'd0);
    ticks(1);
    chk("dn_floor", 32'(time_bcd), 32'h0000);

    // DONE restart reloads preset (dir latched down)
    cyc(1, 0, 0, 0, 0);
    chk("reload", 32'(time_bcd), 32'h0010);
    chk("reload_run", 32'(running), 32'd1);
    cyc(0, 1, 0, 0, 0);
    chk("clr_up", 32'(time_bcd), 32'h0000);

    // down start at zero goes straight to DONE
    count_down = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("dn0_exp", 32'(expired), 32'd1);
    chk("dn0_run", 32'(running), 32'd0);
    count_down = 1'b0;
    cyc(0, 1, 0, 0, 0);

    // preset_load ignored while running
    cyc(1, 0, 0, 0, 0);
    preset_bcd = 16'h0500;
    cyc(0, 0, 0, 1, 0);
    chk("pl_ign", 32'(time_bcd), 32'h0000);
    count_down = 1'b1;
    cyc(0, 1, 0, 0, 0);
    chk("clr_dn", 32'(time_bcd), 32'h0010);
    count_down = 1'b0;
    cyc(0, 1, 0, 0, 0);

    // full run to 9:59.9 then one more tick
    cyc(1, 0, 0, 0, 0);
    ticks(5999);
    chk("max", 32'(time_bcd), 32'h9599);
    chk("max_w", 32'(time_w), 32'h9599);
    ticks(1);
    chk("hold", 32'(time_bcd), 32'h9599);
    chk("hold_exp", 32'(expired), 32'd1);
    chk("hold_run", 32'(running), 32'd0);
    chk("wrap", 32'(time_w), 32'h0000);
    chk("wrap_run", 32'(running_w), 32'd1);
    chk("wrap_exp", 32'(expired_w), 32'd0);

    // async reset mid-run
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    ticks(3);
    chk("pre_rst", 32'(time_bcd), 32'h0003);
    reset = 1'b1;
    #1;
    chk("arst_time", 32'(time_bcd), 32'h0000);
    chk("arst_run", 32'(running), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ticks(2);
    chk("post_rst", 32'(time_bcd), 32'h0000);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
